// File: rtl/adc_capture_frontend.sv
// adc_capture_frontend
// Serial capture of two MSB-first ADC channels, parallel sample registers with
// load/hold/clear control, sticky magnitude trigger and post-trigger buffer count.
//
// Ports:
//   clk                  system clock, one serial bit per cycle
//   reset                synchronous, active-high
//   chip_select          active low, conversion in progress
//   data_input_sel       00/11 clear, 01 hold, 10 load new sample pair
//   adc_sdata_a/_b       serial data, channels A and B
//   threshold            unsigned trigger magnitude
//   sample_counter_14    conversion complete while chip_select stays low
//   triggered            sticky trigger flag
//   buffer_full_counter  sticky buffer-full flag
//   sample_a/_b          parallel samples
//   sample_valid         one-cycle strobe, new sample pair loaded
module adc_capture_frontend #(
  parameter int unsigned DATA_W    = 14,
  parameter int unsigned BUF_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chip_select,
  input  logic [1:0]        data_input_sel,
  input  logic              adc_sdata_a,
  input  logic              adc_sdata_b,
  input  logic [DATA_W-1:0] threshold,
  output logic              sample_counter_14,
  output logic              triggered,
  output logic              buffer_full_counter,
  output logic [DATA_W-1:0] sample_a,
  output logic [DATA_W-1:0] sample_b,
  output logic              sample_valid
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned BufW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);
  localparam logic [BufW-1:0] BufFull = BufW'(BUF_DEPTH);

  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_a_q, shift_a_d;
  logic [DATA_W-1:0] shift_b_q, shift_b_d;
  logic [DATA_W-1:0] sample_a_q, sample_a_d;
  logic [DATA_W-1:0] sample_b_q, sample_b_d;
  logic [BufW-1:0]   buf_cnt_q, buf_cnt_d;
  logic              armed_q, armed_d;
  logic              fresh_q, fresh_d;
  logic              valid_q, valid_d;
  logic              trig_q, trig_d;

  logic            clear, load, shifting, completing, hit;
  logic [DATA_W:0] ext_a, mag_a;

  always_comb begin
    clear      = (data_input_sel == 2'b00) || (data_input_sel == 2'b11);
    load       = (data_input_sel == 2'b10) && fresh_q;
    // armed_q blocks capture after reset until chip_select has been seen high,
    // so a conversion interrupted by reset cannot resume mid-word.
    shifting   = !chip_select && armed_q && (bit_cnt_q < CntFull);
    completing = shifting && (bit_cnt_q == CntLast);
    // One extra bit so the most negative code maps to its true magnitude.
    ext_a      = {shift_a_q[DATA_W-1], shift_a_q};
    mag_a      = ext_a[DATA_W] ? -ext_a : ext_a;
    hit        = mag_a >= {1'b0, threshold};
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_a_d  = shift_a_q;
    shift_b_d  = shift_b_q;
    armed_d    = armed_q;
    sample_a_d = sample_a_q;
    sample_b_d = sample_b_q;
    fresh_d    = fresh_q;
    valid_d    = 1'b0;
    trig_d     = trig_q;
    buf_cnt_d  = buf_cnt_q;

    if (chip_select) begin
      bit_cnt_d = '0;
      armed_d   = 1'b1;
    end else if (shifting) begin
      shift_a_d = {shift_a_q[DATA_W-2:0], adc_sdata_a};
      shift_b_d = {shift_b_q[DATA_W-2:0], adc_sdata_b};
      bit_cnt_d = bit_cnt_q + CntW'(1);
    end

    if (clear) begin
      sample_a_d = '0;
      sample_b_d = '0;
      fresh_d    = 1'b0;
      trig_d     = 1'b0;
      buf_cnt_d  = '0;
    end else begin
      if (load) begin
        sample_a_d = shift_a_q;
        sample_b_d = shift_b_q;
        valid_d    = 1'b1;
        fresh_d    = 1'b0;
        if (hit) begin
          trig_d = 1'b1;
        end
        if ((trig_q || hit) && (buf_cnt_q != BufFull)) begin
          buf_cnt_d = buf_cnt_q + BufW'(1);
        end
      end
      if (completing) begin
        fresh_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      shift_a_q  <= '0;
      shift_b_q  <= '0;
      armed_q    <= 1'b0;
      sample_a_q <= '0;
      sample_b_q <= '0;
      fresh_q    <= 1'b0;
      valid_q    <= 1'b0;
      trig_q     <= 1'b0;
      buf_cnt_q  <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_a_q  <= shift_a_d;
      shift_b_q  <= shift_b_d;
      armed_q    <= armed_d;
      sample_a_q <= sample_a_d;
      sample_b_q <= sample_b_d;
      fresh_q    <= fresh_d;
      valid_q    <= valid_d;
      trig_q     <= trig_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

  assign sample_counter_14   = (bit_cnt_q == CntFull) && !chip_select;
  assign triggered           = trig_q;
  assign buffer_full_counter = (buf_cnt_q == BufFull);
  assign sample_a            = sample_a_q;
  assign sample_b            = sample_b_q;
  assign sample_valid        = valid_q;

endmodule

// File: tb/tb_adc_capture_frontend.sv
module tb_adc_capture_frontend;

  localparam int DW = 14;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          chip_select = 1'b1;
  logic [1:0]    data_input_sel = 2'b01;
  logic          adc_sdata_a = 1'b0;
  logic          adc_sdata_b = 1'b0;
  logic [DW-1:0] threshold = 14'h3FFF;
  logic          sample_counter_14, triggered, buffer_full_counter, sample_valid;
  logic [DW-1:0] sample_a, sample_b;

  adc_capture_frontend #(.DATA_W(DW), .BUF_DEPTH(BD)) dut (
    .clk                 (clk),
    .reset               (reset),
    .chip_select         (chip_select),
    .data_input_sel      (data_input_sel),
    .adc_sdata_a         (adc_sdata_a),
    .adc_sdata_b         (adc_sdata_b),
    .threshold           (threshold),
    .sample_counter_14   (sample_counter_14),
    .triggered           (triggered),
    .buffer_full_counter (buffer_full_counter),
    .sample_a            (sample_a),
    .sample_b            (sample_b),
    .sample_valid        (sample_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  logic last_sc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a conversion is a count of received bits plus the word
  // accumulated from them; control follows the load/hold/clear rules directly.
  int m_bits, m_wa, m_wb, m_sa, m_sb, m_buf;
  bit m_armed, m_fresh, m_valid, m_trig;

  function automatic int mag(input int w);
    int v;
    v = w;
    if (v >= 8192) v -= 16384;
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_bits = 0; m_wa = 0; m_wb = 0; m_sa = 0; m_sb = 0; m_buf = 0;
      m_armed = 0; m_fresh = 0; m_valid = 0; m_trig = 0;
    end else begin
      bit clr, ld;
      clr = (data_input_sel == 2'b00) || (data_input_sel == 2'b11);
      ld = (data_input_sel == 2'b10) && m_fresh;
      m_valid = ld;
      if (clr) begin
        m_sa = 0; m_sb = 0; m_trig = 0; m_buf = 0; m_fresh = 0;
      end else if (ld) begin
        m_sa = m_wa; m_sb = m_wb; m_fresh = 0;
        if (mag(m_wa) >= int'(threshold)) m_trig = 1;
        if (m_trig && m_buf < BD) m_buf++;
      end
      if (chip_select) begin
        m_bits = 0; m_armed = 1;
      end else if (m_armed && m_bits < DW) begin
        m_wa = ((m_wa * 2) + int'(adc_sdata_a)) % 16384;
        m_wb = ((m_wb * 2) + int'(adc_sdata_b)) % 16384;
        m_bits++;
        if (m_bits == DW && !clr) m_fresh = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (sample_valid === 1'b1) vcnt++;
    chk("sample_a", 32'(sample_a), 32'(m_sa));
    chk("sample_b", 32'(sample_b), 32'(m_sb));
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("triggered", 32'(triggered), 32'(m_trig));
    chk("buffer_full", 32'(buffer_full_counter), 32'(m_buf == BD));
    chk("sample_counter_14", 32'(sample_counter_14), 32'((m_bits == DW) && !chip_select));
  end

  task automatic convert(input int a, input int b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      chip_select = 1'b0;
      adc_sdata_a = a[DW-1-i];
      adc_sdata_b = b[DW-1-i];
    end
    @(negedge clk);
    last_sc = sample_counter_14;
    adc_sdata_a = 1'($urandom);
    adc_sdata_b = 1'($urandom);
    @(negedge clk);
    chip_select = 1'b1;
  endtask

  task automatic sel_burst(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_input_sel = s;
    end
    @(negedge clk);
    data_input_sel = 2'b01;
  endtask

  int v0;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset sample_a", 32'(sample_a), 32'h0);
    chk("reset flags", 32'({triggered, buffer_full_counter, sample_valid}), 32'h0);
    reset = 1'b0;

    // Reset after 7 bits; chip_select stays low, so nothing may complete.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); chip_select = 1'b0; adc_sdata_a = 1'b1;
    end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (16) @(negedge clk);
    chk("no flag before restart", 32'(sample_counter_14), 32'h0);
    chip_select = 1'b1;

    convert(32'h1ABC, 32'h0555, DW);
    chk("sc14 after 14 edges", 32'(last_sc), 32'h1);
    v0 = vcnt;
    sel_burst(2'b10, 5);
    chk("load sample_a", 32'(sample_a), 32'h1ABC);
    chk("load sample_b", 32'(sample_b), 32'h0555);
    chk("single strobe", 32'(vcnt - v0), 32'h1);

    // Abort after 10 bits.
    convert(32'h0123, 32'h3210, 10);
    chk("abort sc14", 32'(last_sc), 32'h0);
    v0 = vcnt;
    sel_burst(2'b10, 3);
    chk("abort holds", 32'(sample_a), 32'h1ABC);
    chk("abort no strobe", 32'(vcnt - v0), 32'h0);

    // Threshold edge: 1023 below, -1024 at threshold.
    threshold = 14'h0400;
    convert(32'h03FF, 32'h0001, DW);
    sel_burst(2'b10, 1);
    chk("no trig 0x03FF", 32'(triggered), 32'h0);
    convert(32'h3C00, 32'h0002, DW);
    sel_burst(2'b10, 1);
    chk("trig -1024", 32'(triggered), 32'h1);
    sel_burst(2'b01, 3);
    sel_burst(2'b10, 2);
    chk("trig sticky", 32'(triggered), 32'h1);

    // -8192 magnitude, then buffer fill to saturation.
    sel_burst(2'b00, 1);
    chk("clear trig", 32'(triggered), 32'h0);
    threshold = 14'h1FFF;
    for (int k = 1; k <= 6; k++) begin
      convert((k == 1) ? 32'h2000 : 32'h0005, 32'(k), DW);
      sel_burst(2'b10, 1);
      if (k == 1) chk("trig -8192", 32'(triggered), 32'h1);
      if (k == 3) chk("not full at 3", 32'(buffer_full_counter), 32'h0);
      if (k == 4) chk("full at 4", 32'({sample_valid, buffer_full_counter}), 32'h3);
      if (k == 6) chk("full at 6", 32'(buffer_full_counter), 32'h1);
    end

    // Clear in the cycle a triggering load would have happened.
    threshold = 14'h0000;
    convert(32'h1111, 32'h2222, DW);
    v0 = vcnt;
    sel_burst(2'b00, 1);
    chk("clear samples", 32'({sample_a, sample_b}), 32'h0);
    chk("clear flags", 32'({triggered, buffer_full_counter}), 32'h0);
    sel_burst(2'b10, 2);
    chk("clear drops fresh", 32'(vcnt - v0), 32'h0);

    // Randomised traffic.
    for (int it = 0; it < 80; it++) begin
      if ($urandom % 20 == 0) begin
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
      end
      threshold = ($urandom % 2 == 1) ? 14'($urandom_range(0, 9000)) : 14'($urandom);
      convert(int'($urandom % 16384), int'($urandom % 16384),
              ($urandom % 5 == 0) ? int'($urandom_range(1, 13)) : DW);
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        int r;
        logic [1:0] s;
        r = int'($urandom % 8);
        s = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 4) ? 2'b01 : 2'b10;
        sel_burst(s, int'($urandom_range(1, 3)));
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_capture_frontend.md
# adc_capture_frontend

Serial-ADC capture stage between the two hydrophone ADCs and the acquisition controller. Shifts in one 14-bit conversion per channel while the controller holds `chip_select` low, then raises `sample_counter_14` to report a complete conversion. On the controller's `data_input_sel` it loads, holds or clears the parallel sample registers. It also produces the `triggered` and `buffer_full_counter` status inputs the controller consumes.

## Interface
- `DATA_W`, 14: bits per conversion, MSB first, two's complement.
- `BUF_DEPTH`, 1024: post-trigger samples per capture buffer.
- `clk`  in  1  system clock; ADC SCLK is derived from it externally, one serial bit per `clk` cycle.
- `reset`  in  1  synchronous, active-high reset.
- `chip_select`  in  1  from controller, active low: 0 = conversion in progress.
- `data_input_sel`  in  2  from controller: 00 clear, 01 hold, 10 load new, 11 same as 00.
- `adc_sdata_a`, `adc_sdata_b`  in  1 each  serial data, channels A and B.
- `threshold`  in  DATA_W  unsigned trigger magnitude.
- `sample_counter_14`  out  1  conversion complete.
- `triggered`  out  1  sticky trigger flag.
- `buffer_full_counter`  out  1  sticky buffer-full flag.
- `sample_a`, `sample_b`  out  DATA_W each  parallel samples.
- `sample_valid`  out  1  one-cycle strobe, new sample pair loaded.

## Operation
- Bit counter `bit_cnt`, 0..DATA_W, width clog2(DATA_W+1):
  - `chip_select`=1: cleared to 0.
  - `chip_select`=0 and `bit_cnt`<DATA_W: `shift_a <= {shift_a[DATA_W-2:0], adc_sdata_a}` (B likewise), then `bit_cnt`+1.
  - `bit_cnt`=DATA_W: the count holds and further bits are ignored.
- `sample_counter_14` = (`bit_cnt`==DATA_W) && !`chip_select`, decoded from registers.
- `fresh` flag:
  - Set on the clock edge where `bit_cnt` goes DATA_W-1 -> DATA_W.
  - Cleared by a load, by `data_input_sel` 00/11, or by reset.
- `data_input_sel` handling:
  - 00/11: `sample_a`/`sample_b` <= 0. `fresh`, `triggered`, `buffer_full_counter` and the buffer count are cleared.
  - 01: all registers hold.
  - 10 with `fresh`=1: samples <= shift registers, `sample_valid` pulses, `fresh` cleared.
  - 10 with `fresh`=0: hold, no strobe. Held sel=10 produces exactly one load per conversion.
- Trigger:
  - On each load, mag = |sample A being loaded|. Compute it at DATA_W+1 bits so -8192 gives 8192 (no overflow).
  - mag >= `threshold` sets `triggered`. It stays set until sel 00/11 or reset.
  - `threshold`=0 triggers on the first load.
- Buffer count `buf_cnt`, width clog2(BUF_DEPTH)+1:
  - Increments on every `sample_valid` while `triggered` is high, or on the load that sets it (the triggering sample counts as #1).
  - Saturates at BUF_DEPTH. `buffer_full_counter` = (`buf_cnt`==BUF_DEPTH).
- Conversion aborted (`chip_select` rises with `bit_cnt`<DATA_W): the partial data is discarded, `fresh` stays 0, and the next sel=10 loads nothing.
- Clear has priority over load/trigger/count in the same cycle.

## Timing
- Reset, synchronous: all outputs 0. `bit_cnt`, shift registers, `fresh` and `buf_cnt` are 0. Reset mid-conversion discards everything; capture restarts only after `chip_select` goes high then low.
- The first serial bit is sampled on the first rising edge at which `chip_select`=0.
- With `chip_select` low for edges 1..14, `sample_counter_14` is high from the cycle after edge 14 until `chip_select` rises.
- Load latency: `sample_a`/`sample_b` and `sample_valid` update on the first edge where sel=10 and `fresh`=1. `sample_valid` is high for exactly that one following cycle.
- `triggered` and `buf_cnt` update on the same edge as the load. `buffer_full_counter` is high in the cycle the BUF_DEPTH-th triggered sample appears.
- Minimum conversion period is DATA_W + 2 cycles: 14 shift cycles, one CS-high cycle for the load, and one CS-low cycle to restart.

## Test plan
- Reset mid-shift after 7 bits, release, then a full conversion of A=0x1ABC: no flag before the restart; after 14 edges `sample_counter_14`=1; sel=10 gives `sample_a`=0x1ABC and a single `sample_valid` even with sel=10 held for 5 cycles.
- Abort at 10 bits (CS high), then sel=10: `sample_counter_14` never rises, samples hold their prior value, no `sample_valid`.
- `threshold`=0x0400; load A=0x03FF, then A=0x3C00 (-1024): no trigger on the first, `triggered`=1 on the second load; later sel=01 and sel=10 keep it high.
- A=0x2000 (-8192) with `threshold`=0x1FFF: magnitude 8192 triggers and does not wrap.
- BUF_DEPTH=4 override: trigger on load 1; `buffer_full_counter` rises on the edge of triggered load 4 and stays high through load 6 (`buf_cnt` saturates at 4).
- sel=00 in the cycle where sel=10 would have loaded a triggering sample: samples=0, `triggered`=0, `buf_cnt`=0, no `sample_valid`.
